// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit accumulator CPU: opcodes, FSM states,
// flag bit positions, ALU operation codes and small decode helpers.
package cpu_pkg;

  localparam logic [7:0] OPCODE_NOP     = 8'h00;
  localparam logic [7:0] OPCODE_LDA_IMM = 8'h01;
  localparam logic [7:0] OPCODE_ADD_IMM = 8'h02;
  localparam logic [7:0] OPCODE_SUB_IMM = 8'h03;
  localparam logic [7:0] OPCODE_AND_IMM = 8'h04;
  localparam logic [7:0] OPCODE_OR_IMM  = 8'h05;
  localparam logic [7:0] OPCODE_XOR_IMM = 8'h06;
  localparam logic [7:0] OPCODE_NOT     = 8'h07;
  localparam logic [7:0] OPCODE_INC     = 8'h08;
  localparam logic [7:0] OPCODE_DEC     = 8'h09;
  localparam logic [7:0] OPCODE_LDX_IMM = 8'h0A;
  localparam logic [7:0] OPCODE_LDY_IMM = 8'h0B;
  localparam logic [7:0] OPCODE_LDA_ABS = 8'h10;
  localparam logic [7:0] OPCODE_STA_ABS = 8'h11;
  localparam logic [7:0] OPCODE_JMP_ABS = 8'h20;
  localparam logic [7:0] OPCODE_HLT     = 8'hFF;

  // Flag register bit indices ({V,N,Z,C} in bits 3..0)
  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  typedef enum logic [2:0] {
    S_FETCH, S_OPERAND, S_ADDR_HI, S_MEM, S_HALTED
  } state_e;

  typedef enum logic [3:0] {
    ALU_PASS, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_NOT, ALU_INC, ALU_DEC
  } alu_op_e;

  // Map an opcode to its ALU operation; loads and non-ALU opcodes pass B.
  function automatic alu_op_e alu_op_of(input logic [7:0] opc);
    case (opc)
      OPCODE_ADD_IMM: return ALU_ADD;
      OPCODE_SUB_IMM: return ALU_SUB;
      OPCODE_AND_IMM: return ALU_AND;
      OPCODE_OR_IMM:  return ALU_OR;
      OPCODE_XOR_IMM: return ALU_XOR;
      OPCODE_NOT:     return ALU_NOT;
      OPCODE_INC:     return ALU_INC;
      OPCODE_DEC:     return ALU_DEC;
      default:        return ALU_PASS;
    endcase
  endfunction

  function automatic logic is_imm(input logic [7:0] opc);
    return (opc >= OPCODE_LDA_IMM && opc <= OPCODE_XOR_IMM) ||
           opc == OPCODE_LDX_IMM || opc == OPCODE_LDY_IMM;
  endfunction

  function automatic logic is_abs(input logic [7:0] opc);
    return opc == OPCODE_LDA_ABS || opc == OPCODE_STA_ABS ||
           opc == OPCODE_JMP_ABS;
  endfunction

  function automatic logic is_acc_implied(input logic [7:0] opc);
    return opc == OPCODE_NOT || opc == OPCODE_INC || opc == OPCODE_DEC;
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational 8-bit ALU. Produces result plus C/V/N/Z candidates; the
// caller decides which flags actually get committed.
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  alu_op_e    op_i,
  output logic [7:0] res_o,
  output logic       c_o,
  output logic       v_o,
  output logic       n_o,
  output logic       z_o
);

  logic [8:0] sum9;

  // Result and carry/overflow per operation; SUB is A + ~B + 1 so C = !borrow
  always_comb begin
    sum9  = 9'd0;
    res_o = b_i;
    c_o   = 1'b0;
    v_o   = 1'b0;
    case (op_i)
      ALU_ADD: begin
        sum9  = {1'b0, a_i} + {1'b0, b_i};
        res_o = sum9[7:0];
        c_o   = sum9[8];
        v_o   = (a_i[7] == b_i[7]) && (res_o[7] != a_i[7]);
      end
      ALU_SUB: begin
        sum9  = {1'b0, a_i} + {1'b0, ~b_i} + 9'd1;
        res_o = sum9[7:0];
        c_o   = sum9[8];
        v_o   = (a_i[7] != b_i[7]) && (res_o[7] != a_i[7]);
      end
      ALU_AND: res_o = a_i & b_i;
      ALU_OR:  res_o = a_i | b_i;
      ALU_XOR: res_o = a_i ^ b_i;
      ALU_NOT: res_o = ~a_i;
      ALU_INC: begin
        res_o = a_i + 8'd1;
        c_o   = (a_i == 8'hFF);
        v_o   = (a_i == 8'h7F);
      end
      ALU_DEC: begin
        res_o = a_i - 8'd1;
        c_o   = (a_i != 8'h00);
        v_o   = (a_i == 8'h80);
      end
      default: res_o = b_i;
    endcase
  end

  assign n_o = res_o[7];
  assign z_o = (res_o == 8'h00);

endmodule

// File: rtl/cpu8_top.sv
// 8-bit accumulator CPU top: FETCH/OPERAND/ADDR_HI/MEM/HALTED sequencer,
// ACC/X/Y/PC/flags state, and the shared memory bus.
// Define CPU_ABS_MODE_EN to enable LDA/STA/JMP absolute; otherwise those
// opcodes are 1-cycle NOPs and the CPU never drives the data bus.
module cpu8_top
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  inout  wire  [7:0]  data_bus,
  output logic [15:0] addr_bus,
  output logic        mem_read,
  output logic        mem_write,
  output logic [7:0]  acc_out,
  output logic [15:0] pc_out,
  output logic [7:0]  flags_out,
  output logic [7:0]  x_out,
  output logic [7:0]  y_out,
  output logic        halt
);

`ifdef CPU_ABS_MODE_EN
  localparam logic ABS_EN = 1'b1;
  logic [7:0] lo_q, hi_q;
`else
  localparam logic ABS_EN = 1'b0;
`endif

  state_e      state_q;
  logic [15:0] pc_q;
  logic [7:0]  acc_q, x_q, y_q, opc_q;
  logic [3:0]  flags_q, flags_d;
  logic        halt_q;

  logic [7:0]  cur_opc, alu_res;
  logic [15:0] pc_inc;
  alu_op_e     alu_op;
  logic        alu_c, alu_v, alu_n, alu_z;

  // In FETCH the opcode is still on the bus; later states use the latch
  assign cur_opc = (state_q == S_FETCH) ? data_bus : opc_q;
  assign alu_op  = alu_op_of(cur_opc);
  assign pc_inc  = pc_q + 16'd1;

  cpu_alu u_alu (
    .a_i  (acc_q),
    .b_i  (data_bus),
    .op_i (alu_op),
    .res_o(alu_res),
    .c_o  (alu_c),
    .v_o  (alu_v),
    .n_o  (alu_n),
    .z_o  (alu_z)
  );

  // Flags after a register write: Z/N always, C for ADD/SUB, V for arith
  always_comb begin
    flags_d         = flags_q;
    flags_d[FLAG_Z] = alu_z;
    flags_d[FLAG_N] = alu_n;
    if (alu_op == ALU_ADD || alu_op == ALU_SUB)
      flags_d[FLAG_C] = alu_c;
    if (alu_op == ALU_ADD || alu_op == ALU_SUB ||
        alu_op == ALU_INC || alu_op == ALU_DEC)
      flags_d[FLAG_V] = alu_v;
  end

  // Instruction sequencer and architectural state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= 16'h0000;
      acc_q   <= 8'h00;
      x_q     <= 8'h00;
      y_q     <= 8'h00;
      opc_q   <= 8'h00;
      flags_q <= 4'h0;
      halt_q  <= 1'b0;
`ifdef CPU_ABS_MODE_EN
      lo_q    <= 8'h00;
      hi_q    <= 8'h00;
`endif
    end else begin
      case (state_q)
        S_FETCH: begin
          opc_q <= data_bus;
          pc_q  <= pc_inc;
          if (data_bus == OPCODE_HLT) begin
            halt_q  <= 1'b1;
            state_q <= S_HALTED;
          end else if (is_imm(data_bus) || (ABS_EN && is_abs(data_bus))) begin
            state_q <= S_OPERAND;
          end else if (is_acc_implied(data_bus)) begin
            acc_q   <= alu_res;
            flags_q <= flags_d;
          end
        end
        S_OPERAND: begin
          pc_q <= pc_inc;
          if (is_imm(opc_q)) begin
            state_q <= S_FETCH;
            flags_q <= flags_d;
            case (opc_q)
              OPCODE_LDX_IMM: x_q   <= alu_res;
              OPCODE_LDY_IMM: y_q   <= alu_res;
              default:        acc_q <= alu_res;
            endcase
          end else begin
`ifdef CPU_ABS_MODE_EN
            lo_q    <= data_bus;
            state_q <= S_ADDR_HI;
`else
            state_q <= S_FETCH;
`endif
          end
        end
`ifdef CPU_ABS_MODE_EN
        S_ADDR_HI: begin
          hi_q <= data_bus;
          if (opc_q == OPCODE_JMP_ABS) begin
            pc_q    <= {data_bus, lo_q};
            state_q <= S_FETCH;
          end else begin
            pc_q    <= pc_inc;
            state_q <= S_MEM;
          end
        end
        S_MEM: begin
          if (opc_q == OPCODE_LDA_ABS) begin
            acc_q   <= alu_res;
            flags_q <= flags_d;
          end
          state_q <= S_FETCH;
        end
`endif
        S_HALTED: state_q <= S_HALTED;
        default:  state_q <= S_FETCH;
      endcase
    end
  end

  // Bus strobes/address decode; all quiet while reset is held
  always_comb begin
    addr_bus  = 16'h0000;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH, S_OPERAND, S_ADDR_HI: begin
          addr_bus = pc_q;
          mem_read = 1'b1;
        end
`ifdef CPU_ABS_MODE_EN
        S_MEM: begin
          addr_bus  = {hi_q, lo_q};
          mem_read  = (opc_q == OPCODE_LDA_ABS);
          mem_write = (opc_q == OPCODE_STA_ABS);
        end
`endif
        default: ;
      endcase
    end
  end

`ifdef CPU_ABS_MODE_EN
  assign data_bus = mem_write ? acc_q : 8'hzz;
`else
  assign data_bus = 8'hzz;
`endif

  assign acc_out   = acc_q;
  assign pc_out    = pc_q;
  assign flags_out = {4'b0000, flags_q};
  assign x_out     = x_q;
  assign y_out     = y_q;
  assign halt      = halt_q;

endmodule

// File: tb/tb_cpu8_top.sv
// Scoreboard bench for cpu8_top: each test loads a small ROM image, pulses
// reset and queues the expected architectural state at given edge counts;
// a negedge monitor pops and compares when the edge count comes up.
module tb_cpu8_top;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  wire  [7:0]  data_bus;
  logic [15:0] addr_bus, pc_out;
  logic        mem_read, mem_write, halt;
  logic [7:0]  acc_out, flags_out, x_out, y_out;

  cpu8_top dut (
    .clk      (clk),
    .reset    (reset),
    .data_bus (data_bus),
    .addr_bus (addr_bus),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .acc_out  (acc_out),
    .pc_out   (pc_out),
    .flags_out(flags_out),
    .x_out    (x_out),
    .y_out    (y_out),
    .halt     (halt)
  );

  always #5 clk = ~clk;

  // ROM image plus a one-entry RAM overlay holding the last write
  logic [7:0]  mem [0:65535];
  logic        wr_v = 1'b0;
  logic [15:0] wr_a = 16'h0;
  logic [7:0]  wr_d = 8'h0;
  int          wr_cnt = 0;

  assign data_bus = (mem_read && !mem_write) ?
                    ((wr_v && addr_bus == wr_a) ? wr_d : mem[addr_bus]) : 8'hzz;

  always @(posedge clk) begin
    if (mem_write) begin
      wr_v   <= 1'b1;
      wr_a   <= addr_bus;
      wr_d   <= data_bus;
      wr_cnt <= wr_cnt + 1;
    end
  end

  int edges;
  always @(posedge clk or posedge reset) begin
    if (reset) edges <= 0;
    else       edges <= edges + 1;
  end

  typedef struct {
    string       name;
    int          e;
    logic [7:0]  acc, x, y, fl;
    logic [15:0] pc;
    logic        hlt;
    logic        bc, rd, wr;
    logic        ba;
    logic [15:0] addr;
  } exp_t;

  exp_t sbq[$];
  exp_t cur;
  int   n_vec = 0, n_bad = 0;

  // Monitor: compare every queued expectation whose edge count has arrived
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].e == edges) begin
      cur = sbq.pop_front();
      n_vec++;
      if ({acc_out, x_out, y_out, flags_out, pc_out, halt} !==
          {cur.acc, cur.x, cur.y, cur.fl, cur.pc, cur.hlt} ||
          (cur.bc && {mem_read, mem_write} !== {cur.rd, cur.wr}) ||
          (cur.ba && addr_bus !== cur.addr)) begin
        n_bad++;
        $display("FAIL %s@e%0d got acc=%h x=%h y=%h fl=%h pc=%h h=%b rd=%b wr=%b a=%h want acc=%h x=%h y=%h fl=%h pc=%h h=%b rd=%b wr=%b a=%h",
                 cur.name, cur.e, acc_out, x_out, y_out, flags_out, pc_out, halt,
                 mem_read, mem_write, addr_bus, cur.acc, cur.x, cur.y, cur.fl,
                 cur.pc, cur.hlt, cur.rd, cur.wr, cur.addr);
      end
    end
  end

  task automatic ex(input string nm, input int e, input logic [7:0] acc,
                    input logic [7:0] x, input logic [7:0] y, input logic [7:0] fl,
                    input logic [15:0] pc, input logic h, input logic bc,
                    input logic rd, input logic wr, input logic ba,
                    input logic [15:0] ad);
    exp_t t;
    t.name = nm; t.e = e; t.acc = acc; t.x = x; t.y = y; t.fl = fl;
    t.pc = pc; t.hlt = h; t.bc = bc; t.rd = rd; t.wr = wr; t.ba = ba;
    t.addr = ad;
    sbq.push_back(t);
  endtask

  // State-only expectation (bus not checked)
  task automatic exs(input string nm, input int e, input logic [7:0] acc,
                     input logic [7:0] fl, input logic [15:0] pc);
    ex(nm, e, acc, 8'h00, 8'h00, fl, pc, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  // Bounded wait for the scoreboard to empty
  task automatic drain(input string nm);
    int t = 0;
    while (sbq.size() > 0 && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (sbq.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s timeout got %0d pending want 0", nm, sbq.size());
      sbq.delete();
    end
  endtask

  // Load program (MSB-first bytes), reset the CPU and queue reset checks
  task automatic start(input string nm, input logic [127:0] p, input int n);
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    for (int i = 0; i < n; i++) mem[i] = p[8*(n-1-i) +: 8];
    @(negedge clk);
    #1 reset = 1'b1;
    ex({nm, "_rst"}, 0, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 1'b0,
       1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
  endtask

  int wr_base;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    repeat (2) @(negedge clk);

    start("lda", 128'h01_55, 2);
    ex("lda_op", 1, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0001);
    ex("lda", 2, 8'h55, 8'h00, 8'h00, 8'h00, 16'h0002, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0002);
    drain("lda");

    start("add", 128'h01_0A_02_05, 4);
    exs("add_ld", 2, 8'h0A, 8'h00, 16'h0002);
    exs("add", 4, 8'h0F, 8'h00, 16'h0004);
    drain("add");

    start("sub", 128'h01_0A_03_03, 4);
    exs("sub", 4, 8'h07, 8'h01, 16'h0004);
    drain("sub");

    start("sub_brw", 128'h01_03_03_05, 4);
    exs("sub_brw", 4, 8'hFE, 8'h04, 16'h0004);
    drain("sub_brw");

    start("add_cz", 128'h01_FF_02_01, 4);
    exs("add_cz", 4, 8'h00, 8'h03, 16'h0004);
    drain("add_cz");

    start("add_v", 128'h01_7F_02_01, 4);
    exs("add_v", 4, 8'h80, 8'h0C, 16'h0004);
    drain("add_v");

    start("inc", 128'h01_7F_08, 3);
    exs("inc", 3, 8'h80, 8'h0C, 16'h0003);
    drain("inc");

    start("dec", 128'h01_80_09, 3);
    exs("dec_ld", 2, 8'h80, 8'h04, 16'h0002);
    exs("dec", 3, 8'h7F, 8'h08, 16'h0003);
    drain("dec");

    start("and", 128'h01_FF_04_0F, 4);
    exs("and", 4, 8'h0F, 8'h00, 16'h0004);
    drain("and");

    start("or", 128'h01_0F_05_F0, 4);
    exs("or", 4, 8'hFF, 8'h04, 16'h0004);
    drain("or");

    start("xor", 128'h01_FF_06_FF, 4);
    exs("xor", 4, 8'h00, 8'h02, 16'h0004);
    drain("xor");

    start("not", 128'h01_00_07, 3);
    exs("not", 3, 8'hFF, 8'h04, 16'h0003);
    drain("not");

    start("idx", 128'h01_12_0A_AB_0B_CD, 6);
    ex("ldx", 4, 8'h12, 8'hAB, 8'h00, 8'h04, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    ex("ldy", 6, 8'h12, 8'hAB, 8'hCD, 8'h04, 16'h0006, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    drain("idx");

    start("undef", 128'h01_80_5A, 3);
    exs("undef", 3, 8'h80, 8'h04, 16'h0003);
    drain("undef");

    start("hlt", 128'h01_33_FF_01_44, 5);
    ex("hlt", 3, 8'h33, 8'h00, 8'h00, 8'h00, 16'h0003, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    ex("hlt_hold", 8, 8'h33, 8'h00, 8'h00, 8'h00, 16'h0003, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    drain("hlt");

`ifdef CPU_ABS_MODE_EN
    start("jmp", 128'h20_10_00, 3);
    exs("jmp_hi", 2, 8'h00, 8'h00, 16'h0002);
    ex("jmp", 3, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0010);
    exs("jmp_nxt", 4, 8'h00, 8'h00, 16'h0011);
    drain("jmp");

    wr_base = wr_cnt;
    start("abs", 128'h01_3C_11_00_02_01_00_10_00_02, 10);
    exs("abs_ld", 2, 8'h3C, 8'h00, 16'h0002);
    ex("sta_mem", 5, 8'h3C, 8'h00, 8'h00, 8'h00, 16'h0005, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0200);
    ex("sta_done", 6, 8'h3C, 8'h00, 8'h00, 8'h00, 16'h0005, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0005);
    exs("abs_clr", 8, 8'h00, 8'h02, 16'h0007);
    exs("lda_abs", 12, 8'h3C, 8'h00, 16'h000A);
    drain("abs");
    chk("sta_pulses", wr_cnt - wr_base, 32'd1);
    chk("sta_addr", {16'h0, wr_a}, 32'h0000_0200);
    chk("sta_data", {24'h0, wr_d}, 32'h0000_003C);
`else
    start("jmp_nop", 128'h20_10_00, 3);
    exs("jmp_nop1", 1, 8'h00, 8'h00, 16'h0001);
    exs("jmp_nop3", 3, 8'h00, 8'h00, 16'h0003);
    drain("jmp_nop");

    wr_base = wr_cnt;
    start("abs_nop", 128'h01_3C_11_00_02_01_00_10_00_02, 10);
    ex("sta_nop", 5, 8'h3C, 8'h00, 8'h00, 8'h00, 16'h0005, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0005);
    drain("abs_nop");
    repeat (8) @(negedge clk);
    chk("no_write", wr_cnt - wr_base, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu8_top.md
# cpu8_top

8-bit accumulator CPU with X/Y index registers, a 16-bit program counter and a flag register. It fetches and executes instructions over a shared 8-bit bidirectional data bus and a 16-bit address bus, and exposes its architectural state for debug and verification. It is the top of the processor and connects directly to external combinational-read ROM/RAM.

## Interface
- No parameters. Opcode encodings come from the shared package.
- `clk  in  1`: single clock; all state changes on the rising edge.
- `reset  in  1`: asynchronous, active-high reset.
- `data_bus  inout  8`: read data from memory. Driven with ACC only while `mem_write=1`; high-Z otherwise.
- `addr_bus  out  16`: memory address.
- `mem_read  out  1`: memory drives `data_bus` this cycle.
- `mem_write  out  1`: memory captures the write data (ACC) at the next rising edge.
- `acc_out  out  8`: accumulator.
- `pc_out  out  16`: program counter.
- `flags_out  out  8`: {4'b0, V, N, Z, C} (bits 3..0).
- `x_out  out  8`, `y_out  out  8`: index registers.
- `halt  out  1`: CPU stopped by HLT.

## Operation
- FSM states: FETCH, OPERAND, ADDR_HI, MEM, HALTED.
- **FETCH:** `addr_bus=PC`, `mem_read=1`. Latch the opcode and increment PC.
  - Implied opcodes execute in this same edge and return to FETCH.
  - Immediate and absolute opcodes go to OPERAND.
- **OPERAND:** `addr_bus=PC`, `mem_read=1`. Latch the byte and increment PC.
  - Immediate opcodes execute and go to FETCH.
  - Absolute opcodes store the low address byte and go to ADDR_HI.
- **ADDR_HI:** same bus behaviour as OPERAND. Latch the high address byte and increment PC.
  - JMP loads PC and goes to FETCH.
  - Otherwise go to MEM.
- **MEM:** `addr_bus={hi,lo}`.
  - LDA_ABS: `mem_read=1`, ACC ← `data_bus`.
  - STA_ABS: `mem_write=1`, drive ACC onto `data_bus`.
  - Then go to FETCH.
- **HLT:** set `halt`, enter HALTED. HALTED holds all state with both strobes low; only reset exits it.
- **Opcode map** (hex):
  - 00 NOP
  - 01 LDA#, 02 ADD#, 03 SUB#, 04 AND#, 05 OR#, 06 XOR#
  - 07 NOT, 08 INC, 09 DEC (ACC)
  - 0A LDX#, 0B LDY#
  - 10 LDA abs, 11 STA abs, 20 JMP abs
  - FF HLT
  - Any undefined opcode behaves as a 1-cycle NOP.
- **Arithmetic:** 8-bit, wraps modulo 256.
  - ADD: C = carry out.
  - SUB: A + ~imm + 1, with C = NOT borrow.
  - V = signed overflow for ADD, SUB, INC and DEC.
  - Logic ops, NOT and loads: C and V unchanged.
- **Z/N:** updated from the result of every ACC/X/Y write. NOP, STA and JMP leave all flags unchanged.
- **PC:** wraps FFFF→0000.

## Timing
- **Reset values:** PC=0000, ACC=X=Y=00, flags=00, `halt=0`, state=FETCH. While reset is asserted: `mem_read=0`, `mem_write=0`, `addr_bus=0000`, `data_bus` Z.
- **Latency:** implied 1 cycle, immediate 2, JMP 3, LDA/STA abs 4.
- **Result visibility:** ACC/X/Y/flags are visible on the outputs immediately after the executing edge. An immediate instruction at 0000 is complete at the 2nd rising edge after reset deasserts.
- **Buses:** `mem_read`, `mem_write` and `addr_bus` are combinational from state/PC/address latch. `mem_read` and `mem_write` are never both 1.
- **Reset mid-instruction:** the instruction is abandoned; an STA in MEM does not write.

## Configuration
- **`CPU_ABS_MODE_EN` defined:** LDA abs, STA abs and JMP are implemented, along with the ADDR_HI and MEM states.
- **Not defined:** opcodes 10/11/20 decode as 1-cycle NOPs, `mem_write` is constant 0, and `data_bus` is never driven.

## Structure
- **Shared package/header** (`cpu_pkg`): opcode localparams (`OPCODE_*`), FSM state encoding, and flag bit indices.
- **Sub-module:** `cpu_alu`, combinational. Inputs: A, B, op. Outputs: result, C, V, N, Z. It serves ADD/SUB/AND/OR/XOR/NOT/INC/DEC and pass-through loads.

## Test plan
- **LDA immediate:** reset; ROM 01 55 00 → `acc_out`=55 at the 2nd edge after reset release; Z=0, N=0.
- **Arithmetic chain:** 01 0A 02 05 → ACC=0F. 01 0A 03 03 → ACC=07 with C=1. 01 7F 08 → ACC=80 with V=1, N=1. 01 80 09 → ACC=7F with V=1.
- **Logic:** FF AND 0F → 0F. 0F OR F0 → FF. FF XOR FF → 00 with Z=1. 01 00 07 → FF.
- **Index loads:** 0A AB → `x_out`=AB. 0B CD → `y_out`=CD. ACC unchanged in both cases.
- **Absolute mode** (`CPU_ABS_MODE_EN` defined): 01 3C 11 00 02 10 00 02 → RAM[0200]=3C, `mem_write` high for exactly 1 cycle, ACC reloads 3C.
- **Control flow:** 20 10 00 → `pc_out`=0010. FF → `halt`=1 and PC frozen. An undefined opcode (e.g. 5A) advances PC by 1 only.
